// File: rtl/bp_mem_burst_packer.sv
// rtl/bp_mem_burst_packer.sv - packs a burst header plus narrow data beats into one wide lite message.
// Optional: define BP_MEM_BURST_PACKER_REPLICATE_EN to replicate short payloads across the whole block.
module bp_mem_burst_packer #(
  parameter int          header_width_p   = 64,
  parameter int          in_data_width_p  = 64,
  parameter int          out_data_width_p = 512,
  parameter logic [15:0] payload_mask_p   = 16'h0006
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [header_width_p-1:0]   mem_header_i,
  input  logic                        mem_header_v_i,
  output logic                        mem_header_ready_and_o,
  input  logic [in_data_width_p-1:0]  mem_data_i,
  input  logic                        mem_data_v_i,
  output logic                        mem_data_ready_and_o,
  output logic [header_width_p-1:0]   mem_header_o,
  output logic [out_data_width_p-1:0] mem_data_o,
  output logic                        mem_v_o,
  input  logic                        mem_ready_and_i
);

  localparam int lanes_lp     = out_data_width_p / in_data_width_p;
  localparam int cnt_width_lp = (lanes_lp > 1) ? $clog2(lanes_lp) : 1;

  typedef enum logic [1:0] {e_idle, e_data, e_send} state_e;

  state_e                    state_r;
  logic [cnt_width_lp-1:0]   cnt_r;
  logic [cnt_width_lp-1:0]   last_r;
  logic [out_data_width_p-1:0] filled;
  logic [out_data_width_p-1:0] packed_data;

  logic header_fire, data_fire, send_fire;
  assign header_fire = mem_header_v_i & mem_header_ready_and_o;
  assign data_fire   = mem_data_v_i & mem_data_ready_and_o;
  assign send_fire   = mem_v_o & mem_ready_and_i;

  // Index of the final beat: clamp payload bits to the block, at least one beat.
  function automatic logic [cnt_width_lp-1:0] last_beat(input logic [2:0] size);
    int bits;
    int n;
    bits = 8 << size;
    if (bits > out_data_width_p) bits = out_data_width_p;
    n = bits / in_data_width_p;
    if (n < 1) n = 1;
    return cnt_width_lp'(n - 1);
  endfunction

  always_comb begin
    filled = mem_data_o;
    for (int k = 0; k < lanes_lp; k++) begin
      if (cnt_r == cnt_width_lp'(k)) filled[k*in_data_width_p +: in_data_width_p] = mem_data_i;
    end
  end

  // Beat count is a power of two, so lane j mirrors lane (j & last_r).
  always_comb begin
    packed_data = filled;
`ifdef BP_MEM_BURST_PACKER_REPLICATE_EN
    for (int j = 0; j < lanes_lp; j++) begin
      for (int k = 0; k < lanes_lp; k++) begin
        if (cnt_width_lp'(k) == (cnt_width_lp'(j) & last_r))
          packed_data[j*in_data_width_p +: in_data_width_p] = filled[k*in_data_width_p +: in_data_width_p];
      end
    end
`else
    packed_data = filled;
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r                <= e_idle;
      cnt_r                  <= '0;
      last_r                 <= '0;
      mem_header_o           <= '0;
      mem_data_o             <= '0;
      mem_v_o                <= 1'b0;
      mem_header_ready_and_o <= 1'b1;
      mem_data_ready_and_o   <= 1'b0;
    end else begin
      case (state_r)
        e_idle: begin
          if (header_fire) begin
            mem_header_o           <= mem_header_i;
            mem_data_o             <= '0;
            cnt_r                  <= '0;
            mem_header_ready_and_o <= 1'b0;
            if (payload_mask_p[mem_header_i[3:0]]) begin
              last_r               <= last_beat(mem_header_i[6:4]);
              state_r              <= e_data;
              mem_data_ready_and_o <= 1'b1;
            end else begin
              state_r <= e_send;
              mem_v_o <= 1'b1;
            end
          end
        end
        e_data: begin
          if (data_fire) begin
            if (cnt_r == last_r) begin
              mem_data_o           <= packed_data;
              state_r              <= e_send;
              mem_data_ready_and_o <= 1'b0;
              mem_v_o              <= 1'b1;
            end else begin
              mem_data_o <= filled;
              cnt_r      <= cnt_r + 1'b1;
            end
          end
        end
        e_send: begin
          if (send_fire) begin
            state_r                <= e_idle;
            mem_v_o                <= 1'b0;
            mem_header_ready_and_o <= 1'b1;
          end
        end
        default: begin
          state_r                <= e_idle;
          mem_v_o                <= 1'b0;
          mem_header_ready_and_o <= 1'b1;
          mem_data_ready_and_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bp_mem_burst_packer.sv
// tb/tb_bp_mem_burst_packer.sv - scoreboard bench for bp_mem_burst_packer.
module tb_bp_mem_burst_packer;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic [63:0]  mem_header_i = '0;
  logic         mem_header_v_i = 1'b0;
  logic         mem_header_ready_and_o;
  logic [63:0]  mem_data_i = '0;
  logic         mem_data_v_i = 1'b0;
  logic         mem_data_ready_and_o;
  logic [63:0]  mem_header_o;
  logic [511:0] mem_data_o;
  logic         mem_v_o;
  logic         mem_ready_and_i = 1'b0;

  bp_mem_burst_packer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .mem_header_i(mem_header_i), .mem_header_v_i(mem_header_v_i),
    .mem_header_ready_and_o(mem_header_ready_and_o),
    .mem_data_i(mem_data_i), .mem_data_v_i(mem_data_v_i),
    .mem_data_ready_and_o(mem_data_ready_and_o),
    .mem_header_o(mem_header_o), .mem_data_o(mem_data_o),
    .mem_v_o(mem_v_o), .mem_ready_and_i(mem_ready_and_i)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0]  hdr;
    logic [511:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   msgs = 0;
  int   cyc = 0;
  int   hdr_cyc = 0;
  bit   dr_seen = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    exp_t e;
    if (reset_n_i && mem_data_ready_and_o) dr_seen = 1;
    if (reset_n_i && mem_v_o && mem_ready_and_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_msg: header=%h with empty scoreboard", mem_header_o);
      end else begin
        e = exp_q.pop_front();
        msgs++;
        if (mem_header_o !== e.hdr) begin
          bad++;
          $display("FAIL msg_header: got %h want %h", mem_header_o, e.hdr);
        end
        total++;
        if (mem_data_o !== e.data) begin
          bad++;
          $display("FAIL msg_data: got %h want %h", mem_data_o, e.data);
        end
      end
    end
  end

  function automatic logic [63:0] mk_hdr(input logic [3:0] t, input logic [2:0] s);
    logic [56:0] upper;
    upper = {$urandom(), $urandom()};
    return {upper, s, t};
  endfunction

  function automatic int n_beats(input logic [2:0] s);
    int bits;
    bits = 8 << s;
    if (bits > 512) bits = 512;
    return (bits < 64) ? 1 : bits / 64;
  endfunction

  function automatic logic [511:0] exp_data(input int n, input logic [63:0] base);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < n; k++) d[k*64 +: 64] = base + 64'(k);
`ifdef BP_MEM_BURST_PACKER_REPLICATE_EN
    for (int j = n; j < 8; j++) d[j*64 +: 64] = d[(j % n)*64 +: 64];
`endif
    return d;
  endfunction

  task automatic push_exp(input logic [63:0] h, input logic [511:0] d);
    exp_t e;
    e.hdr = h;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_header(input logic [63:0] h);
    int t;
    t = 0;
    mem_header_i = h;
    mem_header_v_i = 1'b1;
    while (!mem_header_ready_and_o && t < 50) begin
      @(posedge clk_i); #1;
      t++;
    end
    if (t >= 50) begin
      total++; bad++;
      $display("FAIL header_accept: ready=%0b after %0d cycles, want 1", mem_header_ready_and_o, t);
    end
    @(posedge clk_i); #1;
    mem_header_v_i = 1'b0;
    hdr_cyc = cyc - 1;
  endtask

  task automatic send_beats(input int n, input logic [63:0] base, input bit gap);
    int t;
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        mem_data_v_i = 1'b0;
        @(posedge clk_i); #1;
      end
      mem_data_i = base + 64'(k);
      mem_data_v_i = 1'b1;
      t = 0;
      while (!mem_data_ready_and_o && t < 50) begin
        @(posedge clk_i); #1;
        t++;
      end
      if (t >= 50) begin
        total++; bad++;
        $display("FAIL beat_accept: beat %0d ready=%0b, want 1", k, mem_data_ready_and_o);
      end
      @(posedge clk_i); #1;
    end
    mem_data_v_i = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!mem_v_o && t < 100) begin
      @(posedge clk_i); #1;
      t++;
    end
    if (t >= 100) begin
      total++; bad++;
      $display("FAIL valid_timeout: mem_v_o=%0b, want 1", mem_v_o);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (mem_v_o !== 1'b0 || mem_data_ready_and_o !== 1'b0 || mem_header_ready_and_o !== 1'b1) begin
      bad++;
      $display("FAIL %s_ctrl: v=%b dready=%b hready=%b want 0 0 1", tag, mem_v_o,
               mem_data_ready_and_o, mem_header_ready_and_o);
    end
    total++;
    if (mem_header_o !== 64'h0 || mem_data_o !== 512'h0) begin
      bad++;
      $display("FAIL %s_regs: header=%h data=%h want 0", tag, mem_header_o, mem_data_o);
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_write_burst();
    logic [63:0] h;
    h = mk_hdr(4'd1, 3'd6);
    mem_ready_and_i = 1'b1;
    push_exp(h, exp_data(8, 64'h0));
    send_header(h);
    send_beats(8, 64'h0, 1'b0);
    wait_valid();
    total++;
    if (cyc - hdr_cyc !== 9) begin
      bad++;
      $display("FAIL write_latency: got %0d want 9", cyc - hdr_cyc);
    end
    @(posedge clk_i); #1;
    total++;
    if (mem_v_o !== 1'b0 || mem_header_ready_and_o !== 1'b1) begin
      bad++;
      $display("FAIL write_done: v=%b hready=%b want 0 1", mem_v_o, mem_header_ready_and_o);
    end
  endtask

  task automatic test_read_no_payload();
    logic [63:0] h;
    h = mk_hdr(4'd0, 3'd6);
    mem_ready_and_i = 1'b1;
    dr_seen = 0;
    push_exp(h, 512'h0);
    send_header(h);
    wait_valid();
    total++;
    if (cyc - hdr_cyc !== 1) begin
      bad++;
      $display("FAIL read_latency: got %0d want 1", cyc - hdr_cyc);
    end
    @(posedge clk_i); #1;
    total++;
    if (mem_v_o !== 1'b0) begin
      bad++;
      $display("FAIL read_one_cycle: v=%b want 0", mem_v_o);
    end
    total++;
    if (dr_seen !== 1'b0) begin
      bad++;
      $display("FAIL read_data_ready: seen=%b want 0", dr_seen);
    end
  endtask

  task automatic test_short_write();
    logic [63:0] h;
    logic [63:0] want_lane;
    h = mk_hdr(4'd1, 3'd3);
    mem_ready_and_i = 1'b0;
    push_exp(h, exp_data(n_beats(3'd3), 64'hDEAD_BEEF_0123_4567));
    send_header(h);
    send_beats(1, 64'hDEAD_BEEF_0123_4567, 1'b0);
    wait_valid();
`ifdef BP_MEM_BURST_PACKER_REPLICATE_EN
    want_lane = 64'hDEAD_BEEF_0123_4567;
`else
    want_lane = 64'h0;
`endif
    total++;
    if (mem_data_o[63:0] !== 64'hDEAD_BEEF_0123_4567 || mem_data_o[511:448] !== want_lane) begin
      bad++;
      $display("FAIL short_lanes: lane0=%h lane7=%h want DEADBEEF01234567 %h",
               mem_data_o[63:0], mem_data_o[511:448], want_lane);
    end
    mem_ready_and_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_stall();
    logic [63:0]  h;
    logic [511:0] d;
    h = mk_hdr(4'd2, 3'd6);
    d = exp_data(8, 64'h1000);
    mem_ready_and_i = 1'b0;
    push_exp(h, d);
    send_header(h);
    send_beats(8, 64'h1000, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (mem_v_o !== 1'b1 || mem_data_o !== d || mem_header_o !== h) begin
        bad++;
        $display("FAIL stall_hold: cycle %0d v=%b data=%h want 1 %h", i, mem_v_o, mem_data_o, d);
      end
      @(posedge clk_i); #1;
    end
    mem_ready_and_i = 1'b1;
    @(posedge clk_i); #1;
    total++;
    if (mem_header_ready_and_o !== 1'b1 || mem_v_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: hready=%b v=%b want 1 0", mem_header_ready_and_o, mem_v_o);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [63:0] h;
    h = mk_hdr(4'd1, 3'd6);
    mem_ready_and_i = 1'b1;
    send_header(h);
    send_beats(3, 64'hBAD0, 1'b0);
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    h = mk_hdr(4'd1, 3'd6);
    push_exp(h, exp_data(8, 64'hA5A5_0000_0000_0000));
    send_header(h);
    send_beats(8, 64'hA5A5_0000_0000_0000, 1'b0);
    wait_valid();
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] ha;
    logic [63:0] hb;
    int          start;
    int          t;
    ha = mk_hdr(4'd0, 3'd2);
    hb = mk_hdr(4'd2, 3'd4);
    start = msgs;
    mem_ready_and_i = 1'b0;
    push_exp(ha, 512'h0);
    send_header(ha);
    mem_header_i = hb;
    mem_header_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem_header_ready_and_o !== 1'b0) begin
        bad++;
        $display("FAIL b2b_blocked: cycle %0d hready=%b want 0", i, mem_header_ready_and_o);
      end
      @(posedge clk_i); #1;
    end
    mem_ready_and_i = 1'b1;
    push_exp(hb, exp_data(n_beats(3'd4), 64'h77));
    send_header(hb);
    send_beats(2, 64'h77, 1'b0);
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk_i); #1;
      t++;
    end
    total++;
    if (msgs - start !== 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d messages want 2", msgs - start);
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_no_payload();
    test_short_write();
    test_stall();
    test_reset_mid_burst();
    test_back_to_back();
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
